// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the byte-to-nibble serializer.
package nibble_ser_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic [NIB_W-1:0] hi;
        logic [NIB_W-1:0] lo;
    } byte_s;

    // Nibble of a byte for a given phase; the order flips with msn_first.
    function automatic logic [NIB_W-1:0] pick_nib(input byte_s b, input logic second,
                                                  input logic msn_first);
        return (msn_first ^ second) ? b.hi : b.lo;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered occupancy and synchronous flush.
module byte_fifo
    import nibble_ser_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  byte_s                    wdata,
    input  logic                     pop,
    output byte_s                    rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    byte_s            mem [DEPTH];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/nibble_serializer.sv
// Buffers bytes in a small FIFO and emits each as two nibbles with valid/ready handshake.
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSN_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [BYTE_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NIB_W-1:0]         out_nib,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level
);

    ser_state_e       state;
    ser_state_e       state_nxt;
    byte_s            sreg;
    byte_s            sreg_nxt;
    byte_s            head;
    logic             full;
    logic             empty;
    logic             push_c;
    logic             pop_c;
    logic             load_c;
    logic             drop_c;
    logic [NIB_W-1:0] nib_nxt;
    logic             valid_nxt;
    logic             last_nxt;

    assign in_ready = !full;
    assign push_c   = in_valid && !full && !flush;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push_c),
        .wdata (byte_s'(in_data)),
        .pop   (pop_c),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            out_nib   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            out_nib   <= nib_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
        end
    end

    // Outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        nib_nxt   = out_nib;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        pop_c     = 1'b0;
        load_c    = 1'b0;
        drop_c    = 1'b0;

        if (flush) begin
            drop_c = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) load_c = 1'b1;
                end
                FIRST: begin
                    if (out_ready) begin
                        state_nxt = SECOND;
                        nib_nxt   = pick_nib(sreg, 1'b1, MSN_FIRST);
                        last_nxt  = 1'b1;
                    end
                end
                SECOND: begin
                    if (out_ready) begin
                        if (!empty) load_c = 1'b1;
                        else        drop_c = 1'b1;
                    end
                end
                default: drop_c = 1'b1;
            endcase
        end

        if (load_c) begin
            pop_c     = 1'b1;
            sreg_nxt  = head;
            state_nxt = FIRST;
            nib_nxt   = pick_nib(head, 1'b0, MSN_FIRST);
            valid_nxt = 1'b1;
            last_nxt  = 1'b0;
        end

        if (drop_c) begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            nib_nxt   = '0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: directed scenarios plus randomized traffic against a queue model.
module tb_nibble_serializer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       out_nib;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [LVL_W-1:0] level;

    logic [7:0]       in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [3:0]       out0_nib;
    logic             out0_valid;
    logic             out0_ready;
    logic             out0_last;
    logic [LVL_W-1:0] level0;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    nibble_serializer #(.DEPTH(DEPTH), .MSN_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_nib(out_nib), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .level(level)
    );

    nibble_serializer #(.DEPTH(DEPTH), .MSN_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in0_data), .in_valid(in0_valid),
        .in_ready(in0_ready), .out_nib(out0_nib), .out_valid(out0_valid), .out_ready(out0_ready),
        .out_last(out0_last), .level(level0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Nibbles handed over downstream, with the cycle they were taken.
    logic [3:0] cap[$];
    longint     capc[$];
    always @(posedge clk) begin
        if (reset && out_valid && out_ready) begin
            cap.push_back(out_nib);
            capc.push_back(cyc);
        end
    end

    // Reference: a byte queue for the FIFO plus the byte currently being shown.
    logic [7:0] m_q[$];
    bit         m_have;
    bit         m_second;
    logic [7:0] m_cur;
    bit         m_acc;

    function automatic logic [3:0] nib_of(input logic [7:0] b, input bit second);
        int v;
        v = int'(b);
        return second ? 4'(v % 16) : 4'(v / 16);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_have   = 1'b0;
            m_second = 1'b0;
            m_cur    = 8'h00;
        end else if (flush) begin
            m_q.delete();
            m_have   = 1'b0;
            m_second = 1'b0;
        end else begin
            m_acc = in_valid && (m_q.size() < int'(DEPTH));
            if (!m_have) begin
                if (m_q.size() > 0) begin
                    m_cur    = m_q.pop_front();
                    m_have   = 1'b1;
                    m_second = 1'b0;
                end
            end else if (out_ready) begin
                if (!m_second) begin
                    m_second = 1'b1;
                end else if (m_q.size() > 0) begin
                    m_cur    = m_q.pop_front();
                    m_second = 1'b0;
                end else begin
                    m_have = 1'b0;
                end
            end
            if (m_acc) m_q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_have));
        chk("out_nib",   32'(out_nib),   m_have ? 32'(nib_of(m_cur, m_second)) : 32'd0);
        chk("out_last",  32'(out_last),  32'(m_have && m_second));
        chk("level",     32'(level),     32'(m_q.size()));
        chk("in_ready",  32'(in_ready),  32'(m_q.size() < int'(DEPTH)));
    end

    task automatic send(input logic [7:0] b, output bit stalled);
        int k;
        k = 0;
        stalled = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            stalled = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("send_timeout", 32'(k < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cap(input int n, input string name);
        int k;
        k = 0;
        while (cap.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(cap.size() >= n), 32'd1);
    endtask

    initial begin
        logic [7:0] stream[4];
        logic [3:0] exp34[8];
        logic [7:0] bp_bytes[4];
        logic [3:0] exp35[6];
        bit         st;
        bit         saw_stall;
        int         acc;

        stream   = '{8'h96, 8'hB6, 8'hF6, 8'h96};
        exp34    = '{4'h9, 4'h6, 4'hB, 4'h6, 4'hF, 4'h6, 4'h9, 4'h6};
        bp_bytes = '{8'h96, 8'h12, 8'h34, 8'h56};
        exp35    = '{4'h9, 4'h6, 4'h1, 4'h2, 4'h3, 4'h4};

        reset = 1'b0; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        in0_data = 8'h00; in0_valid = 1'b0; out0_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_level",     32'(level),     32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: first nibble visible in the cycle before push edge + 2.
        in_data = 8'h96; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("single_lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_v0", 32'(out_valid), 32'd1);
        chk("single_n0", 32'(out_nib),   32'h9);
        chk("single_l0", 32'(out_last),  32'd0);
        @(negedge clk);
        chk("single_n1", 32'(out_nib),   32'h6);
        chk("single_l1", 32'(out_last),  32'd1);
        @(negedge clk);
        chk("single_done", 32'(out_valid), 32'd0);

        // Back-to-back stream with out_ready held high.
        cap.delete(); capc.delete();
        saw_stall = 1'b0;
        foreach (stream[i]) begin
            send(stream[i], st);
            if (st) saw_stall = 1'b1;
        end
        wait_cap(8, "stream_timeout");
        foreach (exp34[i]) if (i < cap.size()) chk($sformatf("stream_nib%0d", i), 32'(cap[i]), 32'(exp34[i]));
        if (capc.size() >= 8) chk("stream_gap", 32'(capc[7] - capc[0]), 32'd7);
        chk("stream_stall", 32'(saw_stall), 32'd1);

        // Backpressure: DEPTH+1 bytes fit, then everything drains in order.
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        foreach (bp_bytes[i]) begin
            in_data = bp_bytes[i]; in_valid = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc),       32'd3);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_level",    32'(level),     32'd2);
        chk("bp_nib",      32'(out_nib),   32'h9);
        chk("bp_valid",    32'(out_valid), 32'd1);
        cap.delete(); capc.delete();
        out_ready = 1'b1;
        wait_cap(6, "bp_timeout");
        repeat (4) @(negedge clk);
        chk("bp_count", 32'(cap.size()), 32'd6);
        foreach (exp35[i]) if (i < cap.size()) chk($sformatf("bp_nib%0d", i), 32'(cap[i]), 32'(exp35[i]));

        // Reset while in SECOND with a full FIFO.
        out_ready = 1'b0;
        foreach (bp_bytes[i]) begin
            if (i < 3) begin
                in_data = 8'h11 * 8'(i + 1); in_valid = 1'b1;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pre_rst_last",  32'(out_last), 32'd1);
        chk("pre_rst_level", 32'(level),    32'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_valid",    32'(out_valid), 32'd0);
        chk("async_nib",      32'(out_nib),   32'd0);
        chk("async_last",     32'(out_last),  32'd0);
        chk("async_level",    32'(level),     32'd0);
        chk("async_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b1;
        cap.delete(); capc.delete();
        out_ready = 1'b1; in_data = 8'h5A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_count", 32'(cap.size()), 32'd2);
        if (cap.size() >= 2) begin
            chk("rst_nib0", 32'(cap[0]), 32'h5);
            chk("rst_nib1", 32'(cap[1]), 32'hA);
        end

        // Flush in the cycle a pop and a push would both happen.
        cap.delete(); capc.delete();
        in_data = 8'h77; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_level", 32'(level),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        repeat (6) @(negedge clk);
        chk("flush_none", 32'(cap.size()), 32'd0);

        // Low nibble first.
        in0_data = 8'h3C; in0_valid = 1'b1; out0_ready = 1'b1;
        @(negedge clk);
        in0_valid = 1'b0;
        chk("lsn_early", 32'(out0_valid), 32'd0);
        @(negedge clk);
        chk("lsn_v0", 32'(out0_valid), 32'd1);
        chk("lsn_n0", 32'(out0_nib),   32'hC);
        chk("lsn_l0", 32'(out0_last),  32'd0);
        @(negedge clk);
        chk("lsn_n1", 32'(out0_nib),   32'h3);
        chk("lsn_l1", 32'(out0_last),  32'd1);
        @(negedge clk);
        chk("lsn_done",  32'(out0_valid), 32'd0);
        chk("lsn_level", 32'(level0),     32'd0);
        chk("lsn_ready", 32'(in0_ready),  32'd1);

        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
